mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single external memory port between the instruction-fetch side and the load/store side of the core. It grants one requester at a time and latches its address, write data, size and direction. It drives the memory port with a held request until `memReady`, then returns a one-cycle response pulse to the granted requester. A cycle-count watchdog turns a hung memory access into an error response instead of a core stall.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_watchdog.sv | 32 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Holds the FSM state encoding, the grant encoding and the access-size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the external memory port.
// The slave modport is the arbiter's view; master is the core-plus-memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);

    // Handshake: a requester raises *Req with a stable payload and keeps both
    // until its one-cycle *Valid pulse, whose *Err is meaningful only while it
    // is high. memReq is held with a stable payload until memReady is seen.
    logic              instReq;
    logic [31:0]       instAddr;
    logic              instValid;
    logic              instErr;
    logic              dataReq;
    logic              dataWe;
    logic [1:0]        dataSize;
    logic [31:0]       dataAddr;
    logic [DATA_W-1:0] dataWdata;
    logic              dataValid;
    logic              dataErr;
    logic [DATA_W-1:0] rdata;
    logic              memReq;
    logic              memWe;
    logic [1:0]        memSize;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memReady;

    modport slave (
        input  instReq, instAddr, dataReq, dataWe, dataSize, dataAddr, dataWdata,
        input  memRdata, memReady,
        output instValid, instErr, dataValid, dataErr, rdata,
        output memReq, memWe, memSize, memAddr, memWdata
    );

    modport master (
        output instReq, instAddr, dataReq, dataWe, dataSize, dataAddr, dataWdata,
        output memRdata, memReady,
        input  instValid, instErr, dataValid, dataErr, rdata,
        input  memReq, memWe, memSize, memAddr, memWdata
    );

endinterface

// File: rtl/mem_watchdog.sv
// Loadable up-counter with clear and enable; hit flags a count equal to TIMEOUT.
// Loading 1 at grant makes the count equal the current BUSY cycle number.
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [TO_W-1:0] load_val_i,
    input  logic            en_i,
    output logic            hit_o
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign hit_o = (cnt_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one memory port between fetch and
// load/store. Every output comes straight from a register.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output state_t        state_o
);

    state_t            state_q;
    gnt_t              gnt_q;
    gnt_t              last_gnt_q;
    gnt_t              gnt_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [1:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              inst_valid_q;
    logic              inst_err_q;
    logic              data_valid_q;
    logic              data_err_q;
    logic              any_req_d;
    logic              wd_hit;

    assign any_req_d = bus.instReq || bus.dataReq;

    // Data wins when it is alone or when fetch held the port last time.
    always_comb begin
        gnt_d = GNT_INST;
        if (bus.dataReq && (!bus.instReq || last_gnt_q == GNT_INST)) begin
            gnt_d = GNT_DATA;
        end
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == RESP),
        .load_i     ((state_q == IDLE) && any_req_d),
        .load_val_i (TO_W'(1)),
        .en_i       (state_q == BUSY),
        .hit_o      (wd_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_INST;
            last_gnt_q   <= GNT_INST;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_size_q   <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_err_q   <= 1'b0;
            data_valid_q <= 1'b0;
            data_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        gnt_q      <= gnt_d;
                        last_gnt_q <= gnt_d;
                        mem_req_q  <= 1'b1;
                        state_q    <= BUSY;
                        if (gnt_d == GNT_INST) begin
                            mem_we_q    <= 1'b0;
                            mem_size_q  <= SZ_WORD;
                            mem_addr_q  <= bus.instAddr[ADDR_W-1:0];
                            mem_wdata_q <= '0;
                        end else begin
                            mem_we_q    <= bus.dataWe;
                            mem_size_q  <= bus.dataSize;
                            mem_addr_q  <= bus.dataAddr[ADDR_W-1:0];
                            mem_wdata_q <= bus.dataWe ? bus.dataWdata : '0;
                        end
                    end
                end
                BUSY: begin
                    // memReady has priority over a same-cycle watchdog hit.
                    if (bus.memReady || wd_hit) begin
                        mem_req_q    <= 1'b0;
                        state_q      <= RESP;
                        rdata_q      <= bus.memReady ? bus.memRdata : '0;
                        inst_valid_q <= (gnt_q == GNT_INST);
                        data_valid_q <= (gnt_q == GNT_DATA);
                        inst_err_q   <= (gnt_q == GNT_INST) && !bus.memReady;
                        data_err_q   <= (gnt_q == GNT_DATA) && !bus.memReady;
                    end
                end
                RESP: begin
                    inst_valid_q <= 1'b0;
                    inst_err_q   <= 1'b0;
                    data_valid_q <= 1'b0;
                    data_err_q   <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.memReq    = mem_req_q;
    assign bus.memWe     = mem_we_q;
    assign bus.memSize   = mem_size_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memWdata  = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.instValid = inst_valid_q;
    assign bus.instErr   = inst_err_q;
    assign bus.dataValid = data_valid_q;
    assign bus.dataErr   = data_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a short watchdog.
// Expected grants and responses come from the round-robin/timeout rules.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int W       = 2 + DATA_W;
    localparam int MW      = 1 + 2 + ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_dbg;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk     (clk),
        .rst     (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_fail   = 0;
    logic [W-1:0]    exp_q[$];
    logic [MW-1:0]   exp_mem;
    logic [31:0]     i_addr;
    logic [31:0]     d_addr;
    logic [31:0]     d_wdata;
    logic            d_we;
    logic [1:0]      d_size;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instReq   = 1'b0;
        bus.instAddr  = '0;
        bus.dataReq   = 1'b0;
        bus.dataWe    = 1'b0;
        bus.dataSize  = 2'b00;
        bus.dataAddr  = '0;
        bus.dataWdata = '0;
        bus.memRdata  = '0;
        bus.memReady  = 1'b0;
    endtask

    task automatic drive_inst(input logic [31:0] a);
        i_addr       = a;
        bus.instAddr = a;
        bus.instReq  = 1'b1;
    endtask

    task automatic drive_data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd);
        d_we          = we;
        d_size        = sz;
        d_addr        = a;
        d_wdata       = wd;
        bus.dataWe    = we;
        bus.dataSize  = sz;
        bus.dataAddr  = a;
        bus.dataWdata = wd;
        bus.dataReq   = 1'b1;
    endtask

    // Called in an IDLE cycle: the winner must appear on the memory port next cycle.
    task automatic expect_grant(input string tag, input bit is_data);
        int n = 0;
        if (is_data) exp_mem = {d_we, d_size, d_addr[ADDR_W-1:0], (d_we ? d_wdata : 32'h0)};
        else         exp_mem = {1'b0, SZ_WORD, i_addr[ADDR_W-1:0], 32'h0};
        do begin
            tick();
            n++;
        end while (bus.memReq !== 1'b1 && n < 6);
        check({tag, "_lat"}, n, 1);
        check({tag, "_mem"}, {bus.memWe, bus.memSize, bus.memAddr, bus.memWdata}, exp_mem);
    endtask

    task automatic check_resp(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valids"}, {bus.dataValid, bus.instValid}, e[W-1] ? 2'b10 : 2'b01);
            check({tag, "_resp"}, {(bus.dataValid ? bus.dataErr : bus.instErr), bus.rdata},
                  e[W-2:0]);
        end
    endtask

    // Memory model for one access. ready_at is the BUSY cycle (1-based) that
    // returns memReady; anything outside 1..TIMEOUT means the access hangs.
    task automatic serve(input string tag, input bit is_data, input int ready_at,
                         input logic [31:0] rd, input bit toggle_inst, input bit drop);
        int          busy   = 0;
        bit          stable = 1'b1;
        bit          err;
        logic [31:0] erd;
        while (bus.memReq === 1'b1 && busy < 4 * TIMEOUT) begin
            busy++;
            if ({bus.memWe, bus.memSize, bus.memAddr, bus.memWdata} !== exp_mem) stable = 1'b0;
            bus.memReady = (busy == ready_at);
            bus.memRdata = (busy == ready_at) ? rd : $urandom;
            if (toggle_inst) bus.instAddr = $urandom;
            tick();
        end
        bus.memReady = 1'b0;
        err = !(ready_at >= 1 && ready_at <= TIMEOUT);
        erd = err ? 32'h0 : rd;
        check({tag, "_busy"}, busy, err ? TIMEOUT : ready_at);
        check({tag, "_stable"}, stable, 1'b1);
        exp_q.push_back({is_data, err, erd});
        check_resp(tag);
        if (drop) begin
            if (is_data) bus.dataReq = 1'b0;
            else         bus.instReq = 1'b0;
        end
        tick();
        check({tag, "_pulse1"}, {bus.dataValid, bus.instValid}, 2'b00);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit          last_data;
        bit          ip;
        bit          dp;
        bit          win;
        int          ra;

        idle_inputs();

        // Reset
        repeat (3) tick();
        check("rst_mem", {bus.memReq, bus.memWe, bus.memSize, bus.memAddr, bus.memWdata}, 0);
        check("rst_resp", {bus.rdata, bus.instValid, bus.instErr, bus.dataValid, bus.dataErr}, 0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_idle_memreq", bus.memReq, 1'b0);
        check("rst_idle_state", state_dbg, IDLE);

        // Single fetch
        drive_inst(32'h0000_0004);
        expect_grant("fetch", 1'b0);
        check("fetch_state", state_dbg, BUSY);
        serve("fetch", 1'b0, 1, 32'h1234_5678, 1'b0, 1'b1);

        // Store held for 3 BUSY cycles
        drive_data(1'b1, SZ_BYTE, 32'h0080_000C, 32'hA5A5_A5A5);
        expect_grant("store", 1'b1);
        serve("store", 1'b1, 3, 32'h0BAD_F00D, 1'b0, 1'b1);

        // memReady in IDLE is ignored
        bus.memReady = 1'b1;
        tick();
        bus.memReady = 1'b0;
        check("ign_ready_state", state_dbg, IDLE);
        check("ign_ready_mem", {bus.memReq, bus.memWe, bus.memSize, bus.memAddr, bus.memWdata},
              {1'b0, exp_mem});
        tick();

        // instAddr toggling during a load must not disturb the memory port
        drive_data(1'b0, SZ_HALF, 32'hFF12_3456, 32'hDEAD_BEEF);
        expect_grant("ign_inst", 1'b1);
        serve("ign_inst", 1'b1, 2, 32'h5555_AAAA, 1'b1, 1'b1);

        // Timeout: hang, then memReady exactly in the last allowed cycle
        drive_data(1'b0, SZ_WORD, 32'h0000_0100, 32'h0);
        expect_grant("to_hang", 1'b1);
        serve("to_hang", 1'b1, 0, 32'h0, 1'b0, 1'b1);
        drive_data(1'b0, SZ_WORD, 32'h0000_0104, 32'h0);
        expect_grant("to_edge", 1'b1);
        serve("to_edge", 1'b1, TIMEOUT, 32'hCAFE_0004, 1'b0, 1'b1);

        // Contention from reset: data, inst, data, inst
        drive_inst(32'h0000_0040);
        drive_data(1'b1, SZ_WORD, 32'h0000_0800, 32'h1357_9BDF);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            win = (i % 2 == 0);
            expect_grant($sformatf("cont%0d", i), win);
            serve($sformatf("cont%0d", i), win, 1, $urandom, 1'b0, 1'b0);
        end
        bus.instReq = 1'b0;
        bus.dataReq = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of an access
        drive_data(1'b0, SZ_WORD, 32'h0000_0200, 32'h0);
        expect_grant("rst_mid", 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_memreq", bus.memReq, 1'b0);
        check("rst_mid_state", state_dbg, IDLE);
        bus.dataReq = 1'b0;
        tick();
        check("rst_mid_novalid0", {bus.dataValid, bus.instValid}, 2'b00);
        rst_n = 1'b1;
        tick();
        check("rst_mid_novalid1", {bus.dataValid, bus.instValid}, 2'b00);

        // Randomized traffic against the round-robin model
        last_data = 1'b0;
        ip = 1'b0;
        dp = 1'b0;
        for (int r = 0; r < 40; r++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                drive_inst($urandom);
            end
            if (!dp && ($urandom_range(0, 1) == 1 || !ip)) begin
                dp = 1'b1;
                drive_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
            end
            win = dp && (!ip || !last_data);
            last_data = win;
            ra = $urandom_range(0, TIMEOUT + 1);
            expect_grant($sformatf("rnd%0d", r), win);
            serve($sformatf("rnd%0d", r), win, ra, $urandom, 1'b0, 1'b1);
            if (win) dp = 1'b0;
            else     ip = 1'b0;
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
